dbus_aging_arbiter: RTL and testbench

- Arbitrates the shared DDR port between the icache line-fill channel and the dcache read/write channel.
- Keeps at most one DDR transaction in flight.
- Captures each accepted request into internal registers, so a requester may drop valid after its handshake.
- Gives dcache fixed priority, with an aging counter that guarantees icache progress, plus a watchdog that recovers from a hung DDR.

---
 rtl/dbus_aging_arbiter_if.sv | 47 ++++
 rtl/dbus_aging_arbiter.sv | 168 ++++++++++++++++
 tb/tb_dbus_aging_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dbus_aging_arbiter_if.sv
// Bus bundle between the icache/dcache requesters, the DDR port and the arbiter.
// The arbiter connects through the slave modport; the environment drives the master side.
interface dbus_aging_arbiter_if;
    logic         ic_req_valid;
    logic         ic_req_ready;
    logic [63:0]  ic_req_index;
    logic         ic_resp_valid;
    logic [511:0] ic_resp_data;
    logic         dc_req_valid;
    logic         dc_req_ready;
    logic [63:0]  dc_req_index;
    logic         dc_req_write;
    logic [511:0] dc_req_wdata;
    logic [511:0] dc_req_wmask;
    logic         dc_resp_valid;
    logic [511:0] dc_resp_data;
    logic         resp_err;
    logic         ddr_chip_enable;
    logic [63:0]  ddr_index;
    logic         ddr_write_enable;
    logic         ddr_burst_mode;
    logic [511:0] ddr_write_mask;
    logic [511:0] ddr_write_data;
    logic [511:0] ddr_read_data;
    logic         ddr_operation_done;
    logic         ddr_ready;

    modport master (
        output ic_req_valid, ic_req_index,
        input  ic_req_ready, ic_resp_valid, ic_resp_data,
        output dc_req_valid, dc_req_index, dc_req_write, dc_req_wdata, dc_req_wmask,
        input  dc_req_ready, dc_resp_valid, dc_resp_data, resp_err,
        input  ddr_chip_enable, ddr_index, ddr_write_enable, ddr_burst_mode,
        input  ddr_write_mask, ddr_write_data,
        output ddr_read_data, ddr_operation_done, ddr_ready
    );

    modport slave (
        input  ic_req_valid, ic_req_index,
        output ic_req_ready, ic_resp_valid, ic_resp_data,
        input  dc_req_valid, dc_req_index, dc_req_write, dc_req_wdata, dc_req_wmask,
        output dc_req_ready, dc_resp_valid, dc_resp_data, resp_err,
        output ddr_chip_enable, ddr_index, ddr_write_enable, ddr_burst_mode,
        output ddr_write_mask, ddr_write_data,
        input  ddr_read_data, ddr_operation_done, ddr_ready
    );
endinterface

// File: rtl/dbus_aging_arbiter.sv
// Single-outstanding DDR arbiter: dcache has priority, an aging counter forces icache
// progress, and a watchdog aborts transactions the DDR never completes.
module dbus_aging_arbiter #(
    parameter int MAX_STARVE     = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 10
) (
    input logic                 clock,
    input logic                 reset_n,
    dbus_aging_arbiter_if.slave bus
);
    localparam int SW = $clog2(MAX_STARVE + 1);
    localparam logic [SW-1:0]    STARVE_MAX = SW'(MAX_STARVE);
    localparam logic [CNT_W-1:0] WDOG_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

    state_t          state_q;
    logic            owner_ic_q;
    logic [SW-1:0]   starve_q;
    logic [CNT_W-1:0] wdog_q;
    logic            ce_q;
    logic [63:0]     ddr_index_q;
    logic            we_q;
    logic            burst_q;
    logic [511:0]    mask_q;
    logic [511:0]    wdata_q;
    logic            ic_resp_valid_q;
    logic            dc_resp_valid_q;
    logic            resp_err_q;
    logic [511:0]    ic_resp_data_q;
    logic [511:0]    dc_resp_data_q;

    logic            ic_win_s;
    logic            dc_win_s;
    logic            fin_s;
    logic            tmo_s;
    logic [511:0]    resp_word_s;

    // Winner selection in IDLE; ready is suppressed while reset is asserted.
    always_comb begin
        ic_win_s = 1'b0;
        dc_win_s = 1'b0;
        if (reset_n && state_q == IDLE && bus.ddr_ready) begin
            if (bus.ic_req_valid && bus.dc_req_valid) begin
                if (starve_q >= STARVE_MAX) begin
                    ic_win_s = 1'b1;
                end else begin
                    dc_win_s = 1'b1;
                end
            end else begin
                ic_win_s = bus.ic_req_valid;
                dc_win_s = bus.dc_req_valid;
            end
        end else begin
            ic_win_s = 1'b0;
            dc_win_s = 1'b0;
        end
    end

    // Completion: a done in ISSUE/WAIT, or the watchdog expiring in WAIT.
    always_comb begin
        tmo_s = (state_q == WAIT) && !bus.ddr_operation_done && (wdog_q == WDOG_LAST);
        fin_s = ((state_q == ISSUE) && bus.ddr_operation_done) ||
                ((state_q == WAIT) && bus.ddr_operation_done) || tmo_s;
        if (tmo_s) begin
            resp_word_s = 512'd0;
        end else begin
            resp_word_s = bus.ddr_read_data;
        end
    end

    // Transaction FSM with registered DDR and response outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            owner_ic_q      <= 1'b0;
            starve_q        <= '0;
            wdog_q          <= '0;
            ce_q            <= 1'b0;
            ddr_index_q     <= 64'd0;
            we_q            <= 1'b0;
            burst_q         <= 1'b0;
            mask_q          <= 512'd0;
            wdata_q         <= 512'd0;
            ic_resp_valid_q <= 1'b0;
            dc_resp_valid_q <= 1'b0;
            resp_err_q      <= 1'b0;
            ic_resp_data_q  <= 512'd0;
            dc_resp_data_q  <= 512'd0;
        end else begin
            ce_q            <= 1'b0;
            ic_resp_valid_q <= 1'b0;
            dc_resp_valid_q <= 1'b0;
            resp_err_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ic_win_s) begin
                        owner_ic_q  <= 1'b1;
                        ddr_index_q <= bus.ic_req_index;
                        we_q        <= 1'b0;
                        burst_q     <= 1'b1;
                        mask_q      <= 512'd0;
                        wdata_q     <= 512'd0;
                        starve_q    <= '0;
                        ce_q        <= 1'b1;
                        state_q     <= ISSUE;
                    end else if (dc_win_s) begin
                        owner_ic_q  <= 1'b0;
                        ddr_index_q <= bus.dc_req_index;
                        we_q        <= bus.dc_req_write;
                        burst_q     <= 1'b0;
                        mask_q      <= bus.dc_req_wmask;
                        wdata_q     <= bus.dc_req_wdata;
                        ce_q        <= 1'b1;
                        state_q     <= ISSUE;
                        if (bus.ic_req_valid && starve_q < STARVE_MAX) begin
                            starve_q <= starve_q + 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ISSUE: begin
                    wdog_q  <= '0;
                    state_q <= fin_s ? RESP : WAIT;
                end
                WAIT: begin
                    wdog_q  <= wdog_q + 1'b1;
                    state_q <= fin_s ? RESP : WAIT;
                end
                RESP: begin
                    ddr_index_q <= 64'd0;
                    we_q        <= 1'b0;
                    burst_q     <= 1'b0;
                    mask_q      <= 512'd0;
                    wdata_q     <= 512'd0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (fin_s) begin
                resp_err_q <= tmo_s;
                if (owner_ic_q) begin
                    ic_resp_data_q  <= resp_word_s;
                    ic_resp_valid_q <= 1'b1;
                end else begin
                    dc_resp_data_q  <= resp_word_s;
                    dc_resp_valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.ic_req_ready     = ic_win_s;
    assign bus.dc_req_ready     = dc_win_s;
    assign bus.ic_resp_valid    = ic_resp_valid_q;
    assign bus.ic_resp_data     = ic_resp_data_q;
    assign bus.dc_resp_valid    = dc_resp_valid_q;
    assign bus.dc_resp_data     = dc_resp_data_q;
    assign bus.resp_err         = resp_err_q;
    assign bus.ddr_chip_enable  = ce_q;
    assign bus.ddr_index        = ddr_index_q;
    assign bus.ddr_write_enable = we_q;
    assign bus.ddr_burst_mode   = burst_q;
    assign bus.ddr_write_mask   = mask_q;
    assign bus.ddr_write_data   = wdata_q;
endmodule

// File: tb/tb_dbus_aging_arbiter.sv
// Bench for dbus_aging_arbiter: directed scenarios plus random traffic, checked each
// cycle against a transaction-timeline model (accept time, done time, response time).
module tb_dbus_aging_arbiter;
    localparam int MAX_STARVE = 4;
    localparam int TIMEOUT    = 1024;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    dbus_aging_arbiter_if bus();

    dbus_aging_arbiter #(.MAX_STARVE(MAX_STARVE), .TIMEOUT_CYCLES(TIMEOUT), .CNT_W(10)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Transaction-level model state
    bit           m_busy, m_owner_ic, m_err, m_we, acc_ic, acc_dc, extra_done;
    int           m_acc, m_resp_at, m_starve, done_delay;
    logic [63:0]  m_idx;
    logic [511:0] m_mask, m_wdata, m_rdata, m_ic_data, m_dc_data;
    string        grants;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_owner_ic = 0; m_err = 0; m_we = 0; m_starve = 0;
        m_acc = -10; m_resp_at = -1; m_idx = '0; m_mask = '0; m_wdata = '0;
        m_rdata = '0; m_ic_data = '0; m_dc_data = '0;
    endtask

    // Per-cycle prediction and comparison, called on the falling edge.
    task automatic model_cycle();
        bit was_busy, exp_icr, exp_dcr, rv_ic, rv_dc;
        was_busy = m_busy;
        acc_ic = 0; acc_dc = 0; exp_icr = 0; exp_dcr = 0;
        if (!was_busy && bus.ddr_ready) begin
            if (bus.ic_req_valid && bus.dc_req_valid) begin
                if (m_starve >= MAX_STARVE) exp_icr = 1; else exp_dcr = 1;
            end else begin
                exp_icr = bus.ic_req_valid;
                exp_dcr = bus.dc_req_valid;
            end
        end
        rv_ic = was_busy && cyc == m_resp_at && m_owner_ic;
        rv_dc = was_busy && cyc == m_resp_at && !m_owner_ic;
        if (rv_ic) m_ic_data = m_rdata;
        if (rv_dc) m_dc_data = m_rdata;
        chk("ic_req_ready", bus.ic_req_ready, exp_icr);
        chk("dc_req_ready", bus.dc_req_ready, exp_dcr);
        chk("chip_enable", bus.ddr_chip_enable, was_busy && cyc == m_acc + 1);
        chk("ddr_index", bus.ddr_index, was_busy ? m_idx : 64'd0);
        chk("write_enable", bus.ddr_write_enable, was_busy ? m_we : 1'b0);
        chk("burst_mode", bus.ddr_burst_mode, was_busy ? m_owner_ic : 1'b0);
        chk("write_mask", bus.ddr_write_mask, was_busy ? m_mask : 512'd0);
        chk("write_data", bus.ddr_write_data, was_busy ? m_wdata : 512'd0);
        chk("ic_resp_valid", bus.ic_resp_valid, rv_ic);
        chk("dc_resp_valid", bus.dc_resp_valid, rv_dc);
        if (rv_ic || rv_dc) chk("resp_err", bus.resp_err, m_err);
        chk("ic_resp_data", bus.ic_resp_data, m_ic_data);
        chk("dc_resp_data", bus.dc_resp_data, m_dc_data);
        if (bus.ic_req_ready && bus.ic_req_valid) grants = {grants, "i"};
        if (bus.dc_req_ready && bus.dc_req_valid) grants = {grants, "d"};
        // Completion is the first done from the issue cycle on, else the timeout.
        if (was_busy && m_resp_at < 0 && cyc >= m_acc + 1) begin
            if (bus.ddr_operation_done) begin
                m_resp_at = cyc + 1; m_rdata = bus.ddr_read_data; m_err = 0;
            end else if (cyc == m_acc + 1 + TIMEOUT) begin
                m_resp_at = cyc + 1; m_rdata = '0; m_err = 1;
            end
        end
        if (was_busy && cyc == m_resp_at) m_busy = 0;
        if (exp_icr || exp_dcr) begin
            m_busy = 1; m_acc = cyc; m_resp_at = -1; m_owner_ic = exp_icr;
            if (exp_icr) begin
                acc_ic = 1; m_idx = bus.ic_req_index; m_we = 0; m_mask = '0; m_wdata = '0;
                m_starve = 0;
            end else begin
                acc_dc = 1; m_idx = bus.dc_req_index; m_we = bus.dc_req_write;
                m_mask = bus.dc_req_wmask; m_wdata = bus.dc_req_wdata;
                if (bus.ic_req_valid && m_starve < MAX_STARVE) m_starve++;
            end
        end
    endtask

    // One clock: drive the DDR side, check on the falling edge, advance.
    task automatic cycle();
        bus.ddr_read_data = rand512();
        bus.ddr_operation_done = extra_done ||
            (m_busy && m_resp_at < 0 && done_delay >= 0 && cyc == m_acc + 1 + done_delay);
        @(negedge clock);
        model_cycle();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic wait_idle(input int limit);
        for (int k = 0; k < limit && m_busy; k++) cycle();
        chk("txn_complete_bound", m_busy, 1'b0);
    endtask

    task automatic send(input bit is_ic, input logic [63:0] idx, input bit we,
                        input logic [511:0] wd, input logic [511:0] wm, input int dly,
                        input bit finish, output int waited);
        bit got;
        done_delay = dly;
        got = 0; waited = 0;
        if (is_ic) begin
            bus.ic_req_valid = 1; bus.ic_req_index = idx;
        end else begin
            bus.dc_req_valid = 1; bus.dc_req_index = idx; bus.dc_req_write = we;
            bus.dc_req_wdata = wd; bus.dc_req_wmask = wm;
        end
        for (int k = 0; k < 50 && !got; k++) begin
            cycle();
            got = is_ic ? acc_ic : acc_dc;
            if (!got) waited++;
        end
        chk("accept_bound", got, 1'b1);
        bus.ic_req_valid = 0; bus.dc_req_valid = 0;
        if (finish) wait_idle(TIMEOUT + 20);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ic_ready"}, bus.ic_req_ready, 1'b0);
        chk({tag, "_dc_ready"}, bus.dc_req_ready, 1'b0);
        chk({tag, "_ic_rv"}, bus.ic_resp_valid, 1'b0);
        chk({tag, "_dc_rv"}, bus.dc_resp_valid, 1'b0);
        chk({tag, "_ic_data"}, bus.ic_resp_data, 512'd0);
        chk({tag, "_dc_data"}, bus.dc_resp_data, 512'd0);
        chk({tag, "_err"}, bus.resp_err, 1'b0);
        chk({tag, "_ce"}, bus.ddr_chip_enable, 1'b0);
        chk({tag, "_idx"}, bus.ddr_index, 64'd0);
        chk({tag, "_we"}, bus.ddr_write_enable, 1'b0);
        chk({tag, "_burst"}, bus.ddr_burst_mode, 1'b0);
        chk({tag, "_mask"}, bus.ddr_write_mask, 512'd0);
        chk({tag, "_wdata"}, bus.ddr_write_data, 512'd0);
    endtask

    task automatic do_reset(input string tag);
        bus.ic_req_valid = 0; bus.dc_req_valid = 0;
        reset_n = 1'b0;
        #1;
        chk_all_zero(tag);
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    initial begin
        int w;
        bus.ic_req_valid = 0; bus.ic_req_index = '0;
        bus.dc_req_valid = 0; bus.dc_req_index = '0; bus.dc_req_write = 0;
        bus.dc_req_wdata = '0; bus.dc_req_wmask = '0;
        bus.ddr_read_data = '0; bus.ddr_operation_done = 0; bus.ddr_ready = 1;
        extra_done = 0; done_delay = -1; grants = "";
        do_reset("reset");
        repeat (3) cycle();

        // dcache write, done five cycles after the issue pulse
        send(0, 64'h80, 1, rand512(), {512{1'b1}}, 5, 1, w);
        // icache line fill returning an A5 pattern
        bus.ddr_ready = 1;
        begin
            logic [511:0] a5;
            a5 = {64{8'hA5}};
            done_delay = 3;
            bus.ic_req_valid = 1; bus.ic_req_index = 64'h1000;
            cycle();
            chk("ic_accept_first_cycle", acc_ic, 1'b1);
            bus.ic_req_valid = 0;
            repeat (2) cycle();
            bus.ddr_read_data = a5;
            bus.ddr_operation_done = 1;
            @(negedge clock); model_cycle(); @(posedge clock); #1; cyc++;
            bus.ddr_operation_done = 0;
            cycle();
            chk("ic_a5_data", bus.ic_resp_data, a5);
            wait_idle(20);
        end

        // both requesters always valid: aging forces icache every fifth grant
        grants = "";
        done_delay = 1;
        bus.ic_req_valid = 1; bus.dc_req_valid = 1; bus.dc_req_write = 0;
        for (int k = 0; k < 200 && grants.len() < 10; k++) begin
            bus.ic_req_index = {$urandom(), $urandom()};
            bus.dc_req_index = {$urandom(), $urandom()};
            bus.dc_req_wdata = rand512(); bus.dc_req_wmask = rand512();
            cycle();
        end
        bus.ic_req_valid = 0; bus.dc_req_valid = 0;
        n_cmp++;
        assert (grants == "ddddiddddi") else begin
            n_bad++;
            $error("FAIL grant_order: observed %s expected ddddiddddi", grants);
        end
        wait_idle(20);

        // DDR not ready: request waits, then accepted in the cycle ready rises
        bus.ddr_ready = 0;
        bus.dc_req_valid = 1; bus.dc_req_index = 64'h44;
        repeat (5) cycle();
        bus.ddr_ready = 1;
        send(0, 64'h44, 0, '0, '0, 2, 1, w);
        chk("accept_when_ready_rises", w, 0);

        // DDR never answers: watchdog abort, then a late done is ignored
        send(0, 64'h900, 0, '0, '0, -1, 1, w);
        extra_done = 1; cycle(); extra_done = 0;
        repeat (3) cycle();
        send(1, 64'h2000, 0, '0, '0, 0, 1, w);

        // reset during WAIT abandons the transaction
        send(0, 64'h300, 1, rand512(), rand512(), -1, 0, w);
        repeat (3) cycle();
        do_reset("midwait");
        repeat (4) cycle();
        send(0, 64'h301, 1, rand512(), rand512(), 2, 1, w);

        // random traffic
        for (int k = 0; k < 1500; k++) begin
            bus.ic_req_valid = $urandom_range(0, 1);
            bus.dc_req_valid = $urandom_range(0, 1);
            bus.ddr_ready    = ($urandom_range(0, 4) != 0);
            bus.ic_req_index = {$urandom(), $urandom()};
            bus.dc_req_index = {$urandom(), $urandom()};
            bus.dc_req_write = $urandom_range(0, 1);
            bus.dc_req_wdata = rand512();
            bus.dc_req_wmask = rand512();
            if (!m_busy) done_delay = $urandom_range(0, 6);
            extra_done = (!m_busy || m_resp_at >= 0) && ($urandom_range(0, 9) == 0);
            cycle();
        end
        extra_done = 0;
        bus.ic_req_valid = 0; bus.dc_req_valid = 0;
        wait_idle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
